pc_branch_ctrl: RTL and testbench

Parametrised PC sequencer and branch resolver for the pipelined CPU. It generalises the single zero-flag branch to eight condition codes over the cf/zf/nf flags and adds configurable widths and flush depth. It runs the IDLE/RUN/HALT run-control sequence. It sits between the EX stage, which supplies ALU results and branch requests, and instruction fetch, which consumes pc, fetch_valid and flush.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/pc_flag_reg.sv | 46 ++++
 rtl/pc_branch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_branch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the PC sequencer / branch resolver.
//   - run-control state encodings (ST_IDLE/ST_RUN/ST_HALT)
//   - branch condition-code constants (COND_BZ..COND_RSVD)
//   - flag bit positions inside the {nf,zf,cf} flag vector
//   - cond_true(): evaluates a condition code against a flag vector
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [2:0] COND_BZ   = 3'b000;
  localparam logic [2:0] COND_BNZ  = 3'b001;
  localparam logic [2:0] COND_BN   = 3'b010;
  localparam logic [2:0] COND_BNN  = 3'b011;
  localparam logic [2:0] COND_BC   = 3'b100;
  localparam logic [2:0] COND_BNC  = 3'b101;
  localparam logic [2:0] COND_JMP  = 3'b110;
  localparam logic [2:0] COND_RSVD = 3'b111;

  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_NF = 2;

  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
    logic res;
    res = 1'b0;
    case (cond)
      COND_BZ:  res =  flags[FLAG_ZF];
      COND_BNZ: res = !flags[FLAG_ZF];
      COND_BN:  res =  flags[FLAG_NF];
      COND_BNN: res = !flags[FLAG_NF];
      COND_BC:  res =  flags[FLAG_CF];
      COND_BNC: res = !flags[FLAG_CF];
      COND_JMP: res = 1'b1;
      default:  res = 1'b0;  // reserved encoding is never taken
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_flag_reg.sv
// pc_flag_reg: {nf,zf,cf} condition flag register.
// Ports:
//   clock_i, reset_i     clock, synchronous active-high reset
//   upd_i                flag writes permitted this cycle (enabled and running)
//   clr_i                clear all flags (restart out of HALT)
//   flag_we_i            ALU result valid
//   alu_res_i/alu_carry_i  ALU result and carry out
//   flags_o              registered flags
//   flags_eval_o         flags the branch condition is evaluated against
// Build option: FLAG_FWD_EN forwards this cycle's ALU flags to flags_eval_o
// when flag_we_i is set, so a branch can directly follow its flag-setting op.
module pc_flag_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              upd_i,
  input  logic              clr_i,
  input  logic              flag_we_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic              alu_carry_i,
  output logic [2:0]        flags_o,
  output logic [2:0]        flags_eval_o
);
  import cpu_ctrl_pkg::*;

  logic [2:0] flags_q;
  logic [2:0] flags_new;

  assign flags_new = {alu_res_i[DATA_W-1], (alu_res_i == '0), alu_carry_i};

  always_ff @(posedge clock_i) begin
    if (reset_i)                  flags_q <= '0;
    else if (clr_i)               flags_q <= '0;
    else if (upd_i && flag_we_i)  flags_q <= flags_new;
  end

  assign flags_o = flags_q;

`ifdef FLAG_FWD_EN
  assign flags_eval_o = flag_we_i ? flags_new : flags_q;
`else
  assign flags_eval_o = flags_q;
`endif

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: PC sequencer and branch resolver with IDLE/RUN/HALT control.
// Ports:
//   clock_i, reset_i   clock, synchronous active-high reset
//   enable_i           global advance; low freezes every register
//   start_i            IDLE->RUN, or HALT->RUN restart (pc and flags cleared)
//   stall_i            hold pc
//   halt_req_i         HALT decoded; enter HALT holding the current pc
//   br_valid_i, br_cond_i, br_base_i, br_offset_i   branch request from EX
//   flag_we_i, alu_res_i, alu_carry_i               flag update from EX
//   pc_o, fetch_valid_o, flush_o                    to instruction fetch
//   flags_o {nf,zf,cf}, state_o (00 IDLE, 01 RUN, 10 HALT)
// Build option: FLAG_FWD_EN (see pc_flag_reg). Requires DATA_W > PC_W.
module pc_branch_ctrl #(
  parameter int PC_W      = 8,
  parameter int DATA_W    = 16,
  parameter int FLUSH_CYC = 3
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              halt_req_i,
  input  logic              br_valid_i,
  input  logic [2:0]        br_cond_i,
  input  logic [DATA_W-1:0] br_base_i,
  input  logic [PC_W-1:0]   br_offset_i,
  input  logic              flag_we_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic              alu_carry_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              fetch_valid_o,
  output logic              flush_o,
  output logic [2:0]        flags_o,
  output logic [1:0]        state_o
);
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 3;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic              fetch_valid_q;
  logic [CNT_W-1:0]  fcnt_q;
  logic [2:0]        flags_eval;
  logic              flushing;
  logic              taken;
  logic [PC_W-1:0]   target;
  logic              unused_base;

  // Only the low PC_W bits of the base register form the target.
  assign unused_base = ^br_base_i[DATA_W-1:PC_W];

  pc_flag_reg #(.DATA_W(DATA_W)) u_flags (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .upd_i        (enable_i && (state_q == ST_RUN)),
    .clr_i        (enable_i && (state_q == ST_HALT) && start_i),
    .flag_we_i    (flag_we_i),
    .alu_res_i    (alu_res_i),
    .alu_carry_i  (alu_carry_i),
    .flags_o      (flags_o),
    .flags_eval_o (flags_eval)
  );

  // Requests arriving while flushing belong to squashed instructions.
  assign flushing = (fcnt_q != '0);
  assign taken    = br_valid_i && cond_true(br_cond_i, flags_eval) &&
                    (state_q == ST_RUN) && !flushing;
  assign target   = br_base_i[PC_W-1:0] + br_offset_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      fetch_valid_q <= 1'b0;
      fcnt_q        <= '0;
    end else if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q       <= ST_RUN;
            pc_q          <= '0;
            fetch_valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flushing) fcnt_q <= fcnt_q - 1'b1;
          // Branch beats both stall and a same-cycle halt.
          if (taken) begin
            pc_q   <= target;
            fcnt_q <= CNT_W'(FLUSH_CYC);
          end else if (halt_req_i && !flushing) begin
            state_q       <= ST_HALT;
            fetch_valid_q <= 1'b0;
          end else if (!stall_i) begin
            pc_q <= pc_q + 1'b1;
          end
        end
        ST_HALT: begin
          if (start_i) begin
            state_q       <= ST_RUN;
            pc_q          <= '0;
            fetch_valid_q <= 1'b1;
            fcnt_q        <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_o       = flushing;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: a cycle-level reference model runs
// alongside the stimulus and queues the expected outputs; a monitor pops and
// compares them one cycle-edge later. Directed sequences first, then random.
module tb_pc_branch_ctrl;
  localparam int PC_W      = 8;
  localparam int DATA_W    = 16;
  localparam int FLUSH_CYC = 3;
  localparam int PC_MOD    = 1 << PC_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0, start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic              br_valid = 1'b0, flag_we = 1'b0, alu_carry = 1'b0;
  logic [2:0]        br_cond = '0;
  logic [DATA_W-1:0] br_base = '0, alu_res = '0;
  logic [PC_W-1:0]   br_offset = '0;
  logic [PC_W-1:0]   pc;
  logic              fetch_valid, flush;
  logic [2:0]        flags;
  logic [1:0]        state;

  pc_branch_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .start_i(start),
    .stall_i(stall), .halt_req_i(halt_req), .br_valid_i(br_valid),
    .br_cond_i(br_cond), .br_base_i(br_base), .br_offset_i(br_offset),
    .flag_we_i(flag_we), .alu_res_i(alu_res), .alu_carry_i(alu_carry),
    .pc_o(pc), .fetch_valid_o(fetch_valid), .flush_o(flush),
    .flags_o(flags), .state_o(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pc; int fv; int fl; int flags; int st;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 idle, 1 run, 2 halt; flush_left = slots still squashed.
  int m_state = 0, m_pc = 0, m_fv = 0, flush_left = 0;
  int m_nf = 0, m_zf = 0, m_cf = 0;

  function automatic int cond_ok(int c, int n, int z, int cy);
    case (c)
      0: return z;      1: return 1 - z;
      2: return n;      3: return 1 - n;
      4: return cy;     5: return 1 - cy;
      6: return 1;      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int en_n, en_z, en_c, new_n, new_z, new_c, was_flushing, take;
    if (reset) begin
      m_state = 0; m_pc = 0; m_fv = 0; flush_left = 0;
      m_nf = 0; m_zf = 0; m_cf = 0;
    end else if (enable) begin
      if (m_state == 0) begin
        if (start) begin m_state = 1; m_pc = 0; m_fv = 1; end
      end else if (m_state == 2) begin
        if (start) begin
          m_state = 1; m_pc = 0; m_fv = 1; m_nf = 0; m_zf = 0; m_cf = 0;
        end
      end else begin
        new_n = alu_res[DATA_W-1];
        new_z = (alu_res == 0) ? 1 : 0;
        new_c = alu_carry;
        en_n = m_nf; en_z = m_zf; en_c = m_cf;
`ifdef FLAG_FWD_EN
        if (flag_we) begin en_n = new_n; en_z = new_z; en_c = new_c; end
`endif
        was_flushing = (flush_left > 0);
        take = br_valid && !was_flushing && cond_ok(br_cond, en_n, en_z, en_c);
        if (was_flushing) flush_left = flush_left - 1;
        if (take) begin
          m_pc = ((br_base % PC_MOD) + br_offset) % PC_MOD;
          flush_left = FLUSH_CYC;
        end else if (halt_req && !was_flushing) begin
          m_state = 2; m_fv = 0;
        end else if (!stall) begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
        if (flag_we) begin m_nf = new_n; m_zf = new_z; m_cf = new_c; end
      end
    end
    exp_q.push_back('{pc: m_pc, fv: m_fv, fl: (flush_left > 0) ? 1 : 0,
                      flags: m_nf * 4 + m_zf * 2 + m_cf, st: m_state});
  endtask

  // Apply one cycle of inputs and queue what the DUT must show afterwards.
  task automatic cyc(input bit rst, input bit en, input bit st, input bit stl,
                     input bit hr, input bit bv, input int bc, input int bb,
                     input int bo, input bit fw, input int ar, input bit ac);
    @(negedge clock);
    reset = rst; enable = en; start = st; stall = stl; halt_req = hr;
    br_valid = bv; br_cond = bc[2:0]; br_base = bb[DATA_W-1:0];
    br_offset = bo[PC_W-1:0]; flag_we = fw; alu_res = ar[DATA_W-1:0];
    alu_carry = ac;
    model_step();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every edge after stimulus began presents one output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc", int'(pc), e.pc);
        chk("fetch_valid", int'(fetch_valid), e.fv);
        chk("flush", int'(flush), e.fl);
        chk("flags", int'(flags), e.flags);
        chk("state", int'(state), e.st);
      end
    end
  end

  initial begin
    int guard;
    // 1: reset, start, sequential fetch
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 1, 6, 0, 0, 1, 0, 1);   // reset wins over everything
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(3);
    // 2: zf set, then BZ base 0010 + 05 -> 15, three flush slots
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h0000, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 'h0010, 'h05, 0, 0, 0);
    nop(4);
    // 3: alu 8001 -> nf=1 zf=0; BZ not taken, BN taken
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h8001, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 'h0040, 'h01, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 2, 'h0040, 'h02, 0, 0, 0);
    nop(4);
    // 4: JMP F0+20 wraps to 10; JMP + halt inside flush window ignored
    cyc(0, 1, 0, 0, 0, 1, 6, 'h00F0, 'h20, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 6, 'h0000, 'h80, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // stall while flushing
    nop(3);
    // taken branch beats stall and same-cycle halt; reserved never taken
    cyc(0, 1, 0, 1, 1, 1, 6, 'h0033, 'h01, 0, 0, 0);
    nop(3);
    cyc(0, 1, 0, 0, 0, 1, 7, 'h0000, 'h00, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 4, 'h0000, 'h00, 1, 'h0001, 1);  // sets cf
    cyc(0, 1, 0, 0, 0, 1, 5, 'h0000, 'h00, 0, 0, 0);      // BNC not taken
    cyc(0, 1, 0, 0, 0, 1, 4, 'h00FF, 'h02, 0, 0, 0);      // BC -> 01
    nop(3);
    // 5: JMP to 04, run to 07, halt; enable low freezes; restart
    cyc(0, 1, 0, 0, 0, 1, 6, 'h0000, 'h04, 0, 0, 0);
    nop(3);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 6, 'h0011, 'h11, 1, 'h0000, 1);
    cyc(0, 0, 1, 1, 1, 1, 6, 'h0011, 'h11, 1, 'h0000, 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    // 6: flag_we + BZ same cycle (taken only with forwarding)
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h0001, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 'h0020, 'h02, 1, 'h0000, 0);
    nop(4);
    // enable low mid-flush holds the counter
    cyc(0, 1, 0, 0, 0, 1, 6, 'h0000, 'h50, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(4);
    // reset mid-flush
    cyc(0, 1, 0, 0, 0, 1, 6, 'h0000, 'h60, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // random
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 255)), $urandom_range(0, 2) == 0,
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)),
          $urandom_range(0, 1) == 1);
    end
    nop(1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
